ws2812_multi_transmitter: RTL

Parametrised successor to the single-lane bit transmitter. It serialises pixel words onto CHANNELS WS2812-style LED-stripe lines in lockstep, using one shared slot timer. Each line receives NUM_PIXELS pixels of PIXEL_BITS bits, sent MSB first, then a reset/latch gap. A one-word holding register prefetches the next pixel, so consecutive pixels stream without gaps. The block sits between the frame/pixel source (snake renderer, frame buffer reader) and the stripe output pins.

---
 rtl/ws2812_multi_transmitter_pkg.sv | 20 ++
 rtl/ws2812_multi_transmitter_if.sv | 11 +
 rtl/ws2812_multi_transmitter_lane.sv | 42 ++++
 rtl/ws2812_multi_transmitter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ws2812_multi_transmitter_pkg.sv
// Shared types and timing defaults for the multi-lane WS2812 transmitter.
package ws2812_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SLOT  = 2'd2,
      LATCH = 2'd3
   } ws2812_state_e;

   // Defaults for a 25 MHz clk: 400 ns, 800 ns, 50 us.
   localparam int DEF_S_TIME = 10;
   localparam int DEF_L_TIME = 20;
   localparam int DEF_R_TIME = 1250;

   function automatic int cnt_w(input int max_val);
      return $clog2(max_val) + 1;
   endfunction

endpackage

// File: rtl/ws2812_multi_transmitter_if.sv
// Pixel word stream into the transmitter: valid/ready handshake with a CHANNELS-wide word.
interface ws2812_multi_transmitter_if #(
   parameter int DATA_W = 24
) ();
   logic [DATA_W-1:0] pix_data;
   logic              pix_valid;
   logic              pix_ready;

   modport master (output pix_data, output pix_valid, input pix_ready);
   modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/ws2812_multi_transmitter_lane.sv
// One stripe lane: pixel shift register and registered pin, compared against the next slot count.
module ws2812_lane #(
   parameter int PIXEL_BITS = 24,
   parameter int S_TIME     = 10,
   parameter int L_TIME     = 20,
   parameter int SW         = 5
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  load,
   input  logic                  shift,
   input  logic                  active,
   input  logic [PIXEL_BITS-1:0] data,
   input  logic [SW-1:0]         slot_cnt_nxt,
   output logic                  pin
);
   localparam logic [SW-1:0] S_THR = SW'(S_TIME);
   localparam logic [SW-1:0] L_THR = SW'(L_TIME);

   logic [PIXEL_BITS-1:0] sr;
   logic [PIXEL_BITS-1:0] sr_nxt;

   always_comb begin
      sr_nxt = sr;
      if (load)
         sr_nxt = data;
      else if (shift)
         sr_nxt = {sr[PIXEL_BITS-2:0], 1'b0};
   end

   // Pin is computed from next-cycle values so it stays aligned with slot_cnt.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sr  <= '0;
         pin <= 1'b0;
      end else begin
         sr  <= sr_nxt;
         pin <= active & (slot_cnt_nxt < (sr_nxt[PIXEL_BITS-1] ? L_THR : S_THR));
      end
   end

endmodule

// File: rtl/ws2812_multi_transmitter.sv
// Multi-lane WS2812 serialiser: shared slot timer and one-word prefetch feeding CHANNELS lanes.
//
// state | meaning
// IDLE  | lines low, waiting for start
// FETCH | lines low, waiting for the first pixel word
// SLOT  | driving one bit slot on every lane
// LATCH | lines low for the latch gap, then frame_done
module ws2812_multi_transmitter
   import ws2812_pkg::*;
#(
   parameter int CHANNELS   = 1,
   parameter int PIXEL_BITS = 24,
   parameter int NUM_PIXELS = 64,
   parameter int S_TIME     = DEF_S_TIME,
   parameter int L_TIME     = DEF_L_TIME,
   parameter int R_TIME     = DEF_R_TIME
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start,
   output logic                      busy,
   ws2812_multi_transmitter_if.slave pix,
   output logic                      frame_done,
   output logic                      underrun,
   output logic [CHANNELS-1:0]       led_stripe_pin
);
   localparam int SLOT_LEN = S_TIME + L_TIME;
   localparam int SW = cnt_w(SLOT_LEN - 1);
   localparam int BW = cnt_w(PIXEL_BITS - 1);
   localparam int PW = cnt_w(NUM_PIXELS);
   localparam int RW = cnt_w(R_TIME);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_LEN - 1);
   localparam logic [BW-1:0] BIT_TOP   = BW'(PIXEL_BITS - 1);
   localparam logic [PW-1:0] PIX_LAST  = PW'(NUM_PIXELS - 1);
   localparam logic [PW-1:0] PIX_MAX   = PW'(NUM_PIXELS);
   localparam logic [RW-1:0] LAT_TOP   = RW'(R_TIME - 1);

   ws2812_state_e state, state_nxt;

   logic [SW-1:0] slot_cnt, slot_nxt;
   logic [BW-1:0] bit_cnt, bit_nxt;
   logic [PW-1:0] pix_cnt, acc_cnt;
   logic [RW-1:0] lat_cnt;
   logic [CHANNELS*PIXEL_BITS-1:0] hold_data;
   logic hold_full;
   logic start_acc, load, shift, pix_inc, set_underrun;
   logic lat_load, lat_dec, done_nxt, drain, hold_clr, xfer;

   assign busy          = (state != IDLE);
   assign pix.pix_ready = busy & ~hold_full & (acc_cnt < PIX_MAX);
   assign xfer          = pix.pix_valid & pix.pix_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      slot_nxt     = slot_cnt;
      bit_nxt      = bit_cnt;
      start_acc    = 1'b0;
      load         = 1'b0;
      shift        = 1'b0;
      pix_inc      = 1'b0;
      set_underrun = 1'b0;
      lat_load     = 1'b0;
      lat_dec      = 1'b0;
      done_nxt     = 1'b0;
      drain        = 1'b0;
      hold_clr     = 1'b0;
      case (state)
         IDLE: begin
            // A start coinciding with the frame_done pulse is dropped.
            if (start && !frame_done) begin
               start_acc = 1'b1;
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            if (hold_full) begin
               load      = 1'b1;
               drain     = 1'b1;
               bit_nxt   = BIT_TOP;
               slot_nxt  = '0;
               state_nxt = SLOT;
            end
         end
         SLOT: begin
            if (slot_cnt == SLOT_LAST) begin
               slot_nxt = '0;
               if (bit_cnt != '0) begin
                  shift   = 1'b1;
                  bit_nxt = bit_cnt - 1'b1;
               end else begin
                  pix_inc = 1'b1;
                  if (pix_cnt == PIX_LAST) begin
                     lat_load  = 1'b1;
                     state_nxt = LATCH;
                  end else if (hold_full) begin
                     load    = 1'b1;
                     drain   = 1'b1;
                     bit_nxt = BIT_TOP;
                  end else begin
                     set_underrun = 1'b1;
                     lat_load     = 1'b1;
                     state_nxt    = LATCH;
                  end
               end
            end else begin
               slot_nxt = slot_cnt + 1'b1;
            end
         end
         LATCH: begin
            if (lat_cnt == '0) begin
               done_nxt  = 1'b1;
               hold_clr  = 1'b1;
               state_nxt = IDLE;
            end else begin
               lat_dec = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         slot_cnt   <= '0;
         bit_cnt    <= '0;
         pix_cnt    <= '0;
         acc_cnt    <= '0;
         lat_cnt    <= '0;
         hold_full  <= 1'b0;
         hold_data  <= '0;
         underrun   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         slot_cnt   <= slot_nxt;
         bit_cnt    <= bit_nxt;
         frame_done <= done_nxt;
         if (start_acc) begin
            pix_cnt  <= '0;
            acc_cnt  <= '0;
            underrun <= 1'b0;
         end else begin
            if (pix_inc)
               pix_cnt <= pix_cnt + 1'b1;
            if (xfer)
               acc_cnt <= acc_cnt + 1'b1;
            if (set_underrun)
               underrun <= 1'b1;
         end
         if (lat_load)
            lat_cnt <= LAT_TOP;
         else if (lat_dec)
            lat_cnt <= lat_cnt - 1'b1;
         // Words accepted during LATCH are dropped on the way out.
         if (drain || hold_clr)
            hold_full <= 1'b0;
         else if (xfer) begin
            hold_full <= 1'b1;
            hold_data <= pix.pix_data;
         end
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      ws2812_lane #(
         .PIXEL_BITS (PIXEL_BITS),
         .S_TIME     (S_TIME),
         .L_TIME     (L_TIME),
         .SW         (SW)
      ) u_lane (
         .clk          (clk),
         .rstn         (rstn),
         .load         (load),
         .shift        (shift),
         .active       (state_nxt == SLOT),
         .data         (hold_data[c*PIXEL_BITS +: PIXEL_BITS]),
         .slot_cnt_nxt (slot_nxt),
         .pin          (led_stripe_pin[c])
      );
   end

endmodule
